// File: rtl/pipe_ctrl_irq_pkg.sv
// Shared encodings for the pipeline control unit with interrupt support.
// Provides pc_sel codes, FSM states, stage indices and an index-width helper.
package pipe_ctrl_irq_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_VECTOR = 2'd2,
        PC_EPC    = 2'd3
    } pc_sel_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_e;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;

    // Width of an index into n lines; never zero.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_irq_prio_enc.sv
// Lowest-index-first priority encoder over the pending interrupt lines.
// Ports: req (NIRQ) in; idx (index of lowest set bit) and any (req != 0) out.
module irq_prio_enc
    import pipe_ctrl_irq_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic [NIRQ-1:0]          req,
    output logic [idx_w(NIRQ)-1:0]   idx,
    output logic                     any
);

    localparam int IW = idx_w(NIRQ);

    // Scan downwards so the lowest set line is the last one written.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/pipe_ctrl_irq.sv
// Pipeline stage control: stall/flush arbitration plus vectored, non-nested
// interrupt entry/return with EPC capture. Optional macro: PIPE_DEBUG_EN.
// Ports: clk, rst (async, active-low); stall_req, branch_taken, pc_id,
// eret_id, irq, irq_mask in; stage_rst/en/valid, pc_sel, vec_addr, epc,
// in_isr, irq_ack, eret_err out. PIPE_DEBUG_EN adds debug_en, debug_step.
module pipe_ctrl_irq
    import pipe_ctrl_irq_pkg::*;
#(
    parameter int          NSTAGE   = 5,
    parameter int          NIRQ     = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_DEBUG_EN
    input  logic              debug_en,
    input  logic              debug_step,
`endif
    input  logic              stall_req,
    input  logic              branch_taken,
    input  logic [31:0]       pc_id,
    input  logic              eret_id,
    input  logic [NIRQ-1:0]   irq,
    input  logic [NIRQ-1:0]   irq_mask,
    output logic [NSTAGE-1:0] stage_rst,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [1:0]        pc_sel,
    output logic [31:0]       vec_addr,
    output logic [31:0]       epc,
    output logic              in_isr,
    output logic [NIRQ-1:0]   irq_ack,
    output logic              eret_err
);

    localparam int IW = idx_w(NIRQ);

    state_e             state;
    logic [IW-1:0]      idx;
    logic               any;
    logic               hold;
    logic               take_irq;
    logic               take_eret;

    irq_prio_enc #(.NIRQ(NIRQ)) u_enc (
        .req (irq & irq_mask),
        .idx (idx),
        .any (any)
    );

`ifdef PIPE_DEBUG_EN
    // [0],[1] synchroniser, [2] previous sample for edge detection.
    logic [2:0] dbg_q;
    logic       step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dbg_q <= '0;
        else      dbg_q <= {dbg_q[1:0], debug_step};
    end

    assign step = dbg_q[1] & ~dbg_q[2];
    assign hold = debug_en & ~step;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        stage_rst = '0;
        stage_en  = '1;
        pc_sel    = PC_SEQ;
        irq_ack   = '0;
        eret_err  = 1'b0;
        take_irq  = 1'b0;
        take_eret = 1'b0;
        if (!rst) begin
            stage_rst = '1;
            stage_en  = '0;
        end else if (hold) begin
            stage_en = '0;
        end else if (stall_req) begin
            // Freeze IF/ID, inject a bubble into EXE; a branch
            // resolved now is re-evaluated when ID retries.
            stage_en[STG_IF]   = 1'b0;
            stage_en[STG_ID]   = 1'b0;
            stage_rst[STG_EXE] = 1'b1;
        end else if (state == ST_RUN && any &&
                     stage_valid[STG_ID] &&
                     !branch_taken && !eret_id) begin
            // ID instruction is squashed and becomes the return PC;
            // older stages drain so entry is precise.
            take_irq          = 1'b1;
            stage_rst[STG_IF] = 1'b1;
            stage_rst[STG_ID] = 1'b1;
            pc_sel            = PC_VECTOR;
            irq_ack[idx]      = 1'b1;
        end else if (state == ST_ISR && eret_id &&
                     stage_valid[STG_ID]) begin
            take_eret         = 1'b1;
            stage_rst[STG_IF] = 1'b1;
            stage_rst[STG_ID] = 1'b1;
            pc_sel            = PC_EPC;
        end else begin
            if (state == ST_RUN && eret_id) eret_err = 1'b1;
            if (branch_taken) begin
                stage_rst[STG_IF] = 1'b1;
                pc_sel            = PC_BRANCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            epc         <= '0;
            vec_addr    <= VEC_BASE;
            stage_valid <= '0;
        end else begin
            if (take_irq) begin
                state    <= ST_ISR;
                epc      <= pc_id;
                vec_addr <= VEC_BASE + (32'(idx) << 2);
            end else if (take_eret) begin
                state <= ST_RUN;
            end
            if (stage_rst[0])     stage_valid[0] <= 1'b0;
            else if (stage_en[0]) stage_valid[0] <= 1'b1;
            for (int i = 1; i < NSTAGE; i++) begin
                if (stage_rst[i])
                    stage_valid[i] <= 1'b0;
                else if (stage_en[i])
                    stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    assign in_isr = (state == ST_ISR);

endmodule

// File: tb/tb_pipe_ctrl_irq.sv
// Directed self-checking bench for pipe_ctrl_irq (NSTAGE=5, NIRQ=4).
// Covers reset, fill, stall/branch, IRQ entry/return, ERET error, debug step.
module tb_pipe_ctrl_irq;

    logic        clk;
    logic        rst;
    logic        stall_req;
    logic        branch_taken;
    logic [31:0] pc_id;
    logic        eret_id;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic [4:0]  stage_rst;
    logic [4:0]  stage_en;
    logic [4:0]  stage_valid;
    logic [1:0]  pc_sel;
    logic [31:0] vec_addr;
    logic [31:0] epc;
    logic        in_isr;
    logic [3:0]  irq_ack;
    logic        eret_err;
`ifdef PIPE_DEBUG_EN
    logic        debug_en;
    logic        debug_step;
`endif

    int n_chk = 0;
    int n_err = 0;

    pipe_ctrl_irq #(
        .NSTAGE   (5),
        .NIRQ     (4),
        .VEC_BASE (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PIPE_DEBUG_EN
        .debug_en     (debug_en),
        .debug_step   (debug_step),
`endif
        .stall_req    (stall_req),
        .branch_taken (branch_taken),
        .pc_id        (pc_id),
        .eret_id      (eret_id),
        .irq          (irq),
        .irq_mask     (irq_mask),
        .stage_rst    (stage_rst),
        .stage_en     (stage_en),
        .stage_valid  (stage_valid),
        .pc_sel       (pc_sel),
        .vec_addr     (vec_addr),
        .epc          (epc),
        .in_isr       (in_isr),
        .irq_ack      (irq_ack),
        .eret_err     (eret_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (stage_rst !== 5'h1F) begin
            n_err++;
            $display("FAIL rst_stage_rst got %b want %b", stage_rst, 5'h1F);
        end
        n_chk++;
        if (stage_en !== 5'h00 || pc_sel !== 2'd0 || irq_ack !== 4'h0 || eret_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ctrl got en=%b sel=%0d ack=%b err=%b want 0", stage_en, pc_sel, irq_ack, eret_err);
        end
        tick();
        tick();
        n_chk++;
        if (stage_valid !== 5'h00 || epc !== 32'h0 || vec_addr !== 32'h100 || in_isr !== 1'b0) begin
            n_err++;
            $display("FAIL rst_regs got v=%b epc=%h vec=%h isr=%b want 0/0/100/0", stage_valid, epc, vec_addr, in_isr);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (stage_en !== 5'h1F || stage_rst !== 5'h00) begin
            n_err++;
            $display("FAIL rst_release got en=%b rst=%b want 11111/00000", stage_en, stage_rst);
        end
    endtask

    task automatic test_fill();
        logic [4:0] exp;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = 5'((1 << k) - 1);
            n_chk++;
            if (stage_valid !== exp || pc_sel !== 2'd0) begin
                n_err++;
                $display("FAIL fill_%0d got v=%b sel=%0d want v=%b sel=0", k, stage_valid, pc_sel, exp);
            end
        end
    endtask

    task automatic test_stall_branch();
        stall_req    = 1'b1;
        branch_taken = 1'b1;
        #1;
        n_chk++;
        if (stage_en !== 5'b11100 || stage_rst !== 5'b00100 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL stall got en=%b rst=%b sel=%0d want 11100/00100/0", stage_en, stage_rst, pc_sel);
        end
        tick();
        stall_req = 1'b0;
        #1;
        n_chk++;
        if (stage_valid !== 5'b11011) begin
            n_err++;
            $display("FAIL stall_bubble got %b want %b", stage_valid, 5'b11011);
        end
        n_chk++;
        if (stage_rst !== 5'b00001 || pc_sel !== 2'd1 || stage_en !== 5'h1F) begin
            n_err++;
            $display("FAIL branch got rst=%b sel=%0d en=%b want 00001/1/11111", stage_rst, pc_sel, stage_en);
        end
        tick();
        branch_taken = 1'b0;
        n_chk++;
        if (stage_valid !== 5'b10110) begin
            n_err++;
            $display("FAIL branch_valid got %b want %b", stage_valid, 5'b10110);
        end
        for (int k = 0; k < 5; k++) tick();
        n_chk++;
        if (stage_valid !== 5'h1F) begin
            n_err++;
            $display("FAIL refill got %b want 11111", stage_valid);
        end
    endtask

    task automatic test_eret_run();
        eret_id = 1'b1;
        #1;
        n_chk++;
        if (eret_err !== 1'b1 || stage_rst !== 5'h00 || pc_sel !== 2'd0 || stage_en !== 5'h1F) begin
            n_err++;
            $display("FAIL eret_run got err=%b rst=%b sel=%0d en=%b want 1/0/0/1F", eret_err, stage_rst, pc_sel, stage_en);
        end
        tick();
        eret_id = 1'b0;
        #1;
        n_chk++;
        if (eret_err !== 1'b0 || in_isr !== 1'b0 || stage_valid !== 5'h1F) begin
            n_err++;
            $display("FAIL eret_run_after got err=%b isr=%b v=%b want 0/0/1F", eret_err, in_isr, stage_valid);
        end
    endtask

    task automatic test_mask();
        irq      = 4'b0001;
        irq_mask = 4'b1110;
        #1;
        n_chk++;
        if (irq_ack !== 4'h0 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL masked got ack=%b sel=%0d want 0000/0", irq_ack, pc_sel);
        end
        tick();
        irq = 4'h0;
    endtask

    task automatic test_irq_entry();
        irq          = 4'b0110;
        irq_mask     = 4'b1111;
        pc_id        = 32'h40;
        branch_taken = 1'b1;
        #1;
        n_chk++;
        if (irq_ack !== 4'h0 || pc_sel !== 2'd1) begin
            n_err++;
            $display("FAIL defer_branch got ack=%b sel=%0d want 0000/1", irq_ack, pc_sel);
        end
        tick();
        branch_taken = 1'b0;
        #1;
        n_chk++;
        if (irq_ack !== 4'b0010 || pc_sel !== 2'd2 || stage_rst !== 5'b00011) begin
            n_err++;
            $display("FAIL entry got ack=%b sel=%0d rst=%b want 0010/2/00011", irq_ack, pc_sel, stage_rst);
        end
        tick();
        n_chk++;
        if (epc !== 32'h40 || vec_addr !== 32'h104 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL entry_regs got epc=%h vec=%h isr=%b want 40/104/1", epc, vec_addr, in_isr);
        end
    endtask

    task automatic test_back_to_back();
        irq = 4'b0111;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (irq_ack !== 4'h0) begin
                n_err++;
                $display("FAIL isr_ignore_%0d got %b want 0000", k, irq_ack);
            end
            tick();
        end
        eret_id = 1'b1;
        #1;
        n_chk++;
        if (pc_sel !== 2'd3 || stage_rst !== 5'b00011 || irq_ack !== 4'h0 || eret_err !== 1'b0) begin
            n_err++;
            $display("FAIL eret got sel=%0d rst=%b ack=%b err=%b want 3/00011/0000/0", pc_sel, stage_rst, irq_ack, eret_err);
        end
        tick();
        eret_id = 1'b0;
        pc_id   = 32'h80;
        #1;
        n_chk++;
        if (in_isr !== 1'b0 || irq_ack !== 4'h0) begin
            n_err++;
            $display("FAIL eret_after got isr=%b ack=%b want 0/0000", in_isr, irq_ack);
        end
        tick();
        n_chk++;
        if (irq_ack !== 4'h0) begin
            n_err++;
            $display("FAIL reentry_early got %b want 0000", irq_ack);
        end
        tick();
        n_chk++;
        if (irq_ack !== 4'b0001 || pc_sel !== 2'd2) begin
            n_err++;
            $display("FAIL reentry got ack=%b sel=%0d want 0001/2", irq_ack, pc_sel);
        end
        tick();
        irq = 4'h0;
        n_chk++;
        if (epc !== 32'h80 || vec_addr !== 32'h100 || in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL reentry_regs got epc=%h vec=%h isr=%b want 80/100/1", epc, vec_addr, in_isr);
        end
        tick();
        tick();
        eret_id = 1'b1;
        tick();
        eret_id = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_chk++;
        if (in_isr !== 1'b0 || stage_valid !== 5'h1F) begin
            n_err++;
            $display("FAIL return2 got isr=%b v=%b want 0/11111", in_isr, stage_valid);
        end
    endtask

    task automatic test_reset_in_isr();
        irq   = 4'b1000;
        pc_id = 32'h1234;
        #1;
        n_chk++;
        if (irq_ack !== 4'b1000) begin
            n_err++;
            $display("FAIL top_line got %b want 1000", irq_ack);
        end
        tick();
        irq = 4'h0;
        n_chk++;
        if (in_isr !== 1'b1 || vec_addr !== 32'h10C || epc !== 32'h1234) begin
            n_err++;
            $display("FAIL top_regs got isr=%b vec=%h epc=%h want 1/10C/1234", in_isr, vec_addr, epc);
        end
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_isr !== 1'b0 || epc !== 32'h0 || vec_addr !== 32'h100 || stage_valid !== 5'h00) begin
            n_err++;
            $display("FAIL isr_reset got isr=%b epc=%h vec=%h v=%b want 0/0/100/0", in_isr, epc, vec_addr, stage_valid);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) tick();
    endtask

`ifdef PIPE_DEBUG_EN
    task automatic test_debug();
        int hits;
        int first;
        hits  = 0;
        first = -1;
        debug_en = 1'b1;
        #1;
        n_chk++;
        if (stage_en !== 5'h00) begin
            n_err++;
            $display("FAIL dbg_hold got %b want 00000", stage_en);
        end
        @(negedge clk);
        debug_step = 1'b1;
        @(negedge clk);
        debug_step = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (stage_en === 5'h1F) begin
                hits++;
                if (first < 0) first = k;
            end
        end
        n_chk++;
        if (hits !== 1 || first < 0 || first > 3) begin
            n_err++;
            $display("FAIL dbg_step got hits=%0d at=%0d want 1 within 3", hits, first);
        end
        debug_en = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst          = 1'b0;
        stall_req    = 1'b0;
        branch_taken = 1'b0;
        pc_id        = 32'h0;
        eret_id      = 1'b0;
        irq          = 4'h0;
        irq_mask     = 4'h0;
`ifdef PIPE_DEBUG_EN
        debug_en     = 1'b0;
        debug_step   = 1'b0;
`endif
        test_reset();
        test_fill();
        test_stall_branch();
        test_eret_run();
        test_mask();
        test_irq_entry();
        test_back_to_back();
        test_reset_in_isr();
`ifdef PIPE_DEBUG_EN
        test_debug();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
